tcpc_reset_ctrl: RTL

Parametrised multi-port reset controller for the USB Type-C port-controller register block. For each of NUM_PORTS ports it turns host Hard/Cable Reset requests into TCPCI TRANSMIT codes and retries on PHY timeout. It maintains the per-port ALERT, RECEIVE_DETECT and RECEIVE_BYTE_COUNT registers, and raises PHY_Stop_Attempting_Reset when retries are exhausted. It sits between the host register interface and the per-port PHY transmit path.

---
 rtl/tcpc_reset_pkg.sv | 29 ++
 rtl/tcpc_reset_port.sv | 124 ++++++++++++
 rtl/tcpc_reset_ctrl.sv | 54 +++++
 3 files changed

// File: rtl/tcpc_reset_pkg.sv
// Shared types and constants for the Type-C reset controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package tcpc_reset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // TCPCI TRANSMIT type codes for reset signalling
    localparam logic [2:0] TX_HARD_RESET  = 3'b101;
    localparam logic [2:0] TX_CABLE_RESET = 3'b110;

    // ALERT register bit positions
    localparam int ALERT_RX_HARD_RESET = 3;
    localparam int ALERT_TX_FAILED     = 4;
    localparam int ALERT_TX_DISCARDED  = 5;
    localparam int ALERT_TX_SUCCESS    = 6;

    // Packs the TRANSMIT register byte: {2'b00, attempt, 1'b0, code}
    function automatic logic [7:0] tx_byte(input logic [1:0] attempt, input logic [2:0] code);
        return {2'b00, attempt, 1'b0, code};
    endfunction

endpackage

// File: rtl/tcpc_reset_port.sv
// One port: reset-request FSM with ack timeout and retries, plus ALERT/RX_DETECT/RX_BYTE_COUNT.
// Latency: TRANSMIT valid the cycle after the request edge; ALERT updates one edge after DONE/FAIL.
// Backpressure: none; requests while busy are dropped and flagged as TxDiscarded.
module tcpc_reset_port
    import tcpc_reset_pkg::*;
#(
    parameter int RETRY_MAX      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        hard_req,
    input  logic        cable_req,
    input  logic        phy_ack,
    input  logic        rx_hard_reset,
    input  logic [15:0] alert_clr,
    input  logic        rxdet_we,
    input  logic [7:0]  rxdet_wdata,
    input  logic        rxbc_we,
    input  logic [7:0]  rxbc_wdata,
    output logic [7:0]  transmit,
    output logic [15:0] alert,
    output logic [7:0]  rxdet,
    output logic [7:0]  rxbc,
    output logic        stop_pulse,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [1:0]    attempt;
    logic [2:0]    code;
    logic          req;
    logic          clr_rx;
    logic [15:0]   alert_set;

    assign req = hard_req | cable_req;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a received Hard Reset overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (req) state_nxt = ST_SEND;
            ST_SEND:     state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (phy_ack) begin
                    state_nxt = ST_DONE;
                end else if (timer == '0) begin
                    state_nxt = (attempt == 2'(RETRY_MAX)) ? ST_FAIL : ST_SEND;
                end
            end
            ST_DONE:     state_nxt = ST_IDLE;
            ST_FAIL:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (rx_hard_reset) state_nxt = ST_IDLE;
    end

    // Outputs and register side effects decoded from the current state
    always_comb begin
        busy       = (state != ST_IDLE);
        transmit   = ((state == ST_SEND) || (state == ST_WAIT_ACK)) ? tx_byte(attempt, code) : 8'h00;
        stop_pulse = (state == ST_FAIL) && !rx_hard_reset;
        clr_rx     = rx_hard_reset || ((state == ST_IDLE) && req);
        alert_set  = '0;
        if (rx_hard_reset) begin
            alert_set[ALERT_RX_HARD_RESET] = 1'b1;
            if (state != ST_IDLE) alert_set[ALERT_TX_DISCARDED] = 1'b1;
        end
        // dropped request: port busy, line reset in progress, or cable losing to hard
        if (req && ((state != ST_IDLE) || rx_hard_reset)) alert_set[ALERT_TX_DISCARDED] = 1'b1;
        if (hard_req && cable_req) alert_set[ALERT_TX_DISCARDED] = 1'b1;
        if ((state == ST_DONE) && !rx_hard_reset) alert_set[ALERT_TX_SUCCESS] = 1'b1;
        if ((state == ST_FAIL) && !rx_hard_reset) alert_set[ALERT_TX_FAILED] = 1'b1;
    end

    // Datapath: code/attempt latch, ack timer, host-visible registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            attempt <= '0;
            code    <= '0;
            alert   <= '0;
            rxdet   <= '0;
            rxbc    <= '0;
        end else begin
            // sets win over write-1-to-clear on the same bit
            alert <= (alert & ~alert_clr) | alert_set;
            if (clr_rx)        rxdet <= '0;
            else if (rxdet_we) rxdet <= rxdet_wdata;
            if (clr_rx)        rxbc  <= '0;
            else if (rxbc_we)  rxbc  <= rxbc_wdata;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        code    <= hard_req ? TX_HARD_RESET : TX_CABLE_RESET;
                        attempt <= '0;
                    end
                end
                ST_SEND: timer <= TW'(TIMEOUT_CYCLES - 1);
                ST_WAIT_ACK: begin
                    if (!phy_ack) begin
                        if (timer != '0)                     timer   <= timer - 1'b1;
                        else if (attempt != 2'(RETRY_MAX))   attempt <= attempt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tcpc_reset_ctrl.sv
// Multi-port Type-C reset controller: one independent reset FSM per port.
// Latency: per port, TRANSMIT valid the cycle after the request edge.
// Backpressure: none; each port drops requests while busy and flags them in ALERT.
module tcpc_reset_ctrl #(
    parameter int NUM_PORTS      = 2,
    parameter int RETRY_MAX      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    hardReset,
    input  logic [NUM_PORTS-1:0]    cableReset,
    input  logic [NUM_PORTS-1:0]    phy_ack,
    input  logic [NUM_PORTS-1:0]    rx_hard_reset,
    input  logic [16*NUM_PORTS-1:0] alert_clr,
    input  logic [NUM_PORTS-1:0]    rxdet_we,
    input  logic [8*NUM_PORTS-1:0]  rxdet_wdata,
    input  logic [NUM_PORTS-1:0]    rxbc_we,
    input  logic [8*NUM_PORTS-1:0]  rxbc_wdata,
    output logic [8*NUM_PORTS-1:0]  TRANSMIT,
    output logic [16*NUM_PORTS-1:0] ALERT,
    output logic [8*NUM_PORTS-1:0]  RECEIVE_DETECT,
    output logic [8*NUM_PORTS-1:0]  RECEIVE_BYTE_COUNT,
    output logic [NUM_PORTS-1:0]    PHY_Stop_Attempting_Reset,
    output logic [NUM_PORTS-1:0]    busy
);

    // One port instance per slice of the packed vectors
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tcpc_reset_port #(
            .RETRY_MAX      (RETRY_MAX),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_port (
            .CLK           (CLK),
            .reset         (reset),
            .hard_req      (hardReset[p]),
            .cable_req     (cableReset[p]),
            .phy_ack       (phy_ack[p]),
            .rx_hard_reset (rx_hard_reset[p]),
            .alert_clr     (alert_clr[16*p +: 16]),
            .rxdet_we      (rxdet_we[p]),
            .rxdet_wdata   (rxdet_wdata[8*p +: 8]),
            .rxbc_we       (rxbc_we[p]),
            .rxbc_wdata    (rxbc_wdata[8*p +: 8]),
            .transmit      (TRANSMIT[8*p +: 8]),
            .alert         (ALERT[16*p +: 16]),
            .rxdet         (RECEIVE_DETECT[8*p +: 8]),
            .rxbc          (RECEIVE_BYTE_COUNT[8*p +: 8]),
            .stop_pulse    (PHY_Stop_Attempting_Reset[p]),
            .busy          (busy[p])
        );
    end

endmodule
